// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline register with an optional skid entry, synchronous flush
// and saturating backpressure/flush performance counters.
module pipe_stage_reg #(
    parameter int WIDTH     = 32,
    parameter bit SKID_EN   = 1'b1,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 arst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    input  logic                 flush,
    output logic [1:0]           occupancy,
    output logic [CNT_WIDTH-1:0] stall_cnt,
    output logic [CNT_WIDTH-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    state_t                 r_state;
    logic [WIDTH-1:0]       r_main;
    logic [WIDTH-1:0]       r_skid;
    logic                   r_out_valid;
    logic [1:0]             r_occ;
    logic                   r_ready;
    logic [CNT_WIDTH-1:0]   r_stall_cnt;
    logic [CNT_WIDTH-1:0]   r_flush_cnt;

    logic                   w_ready_base;
    logic                   w_push;
    logic                   w_pop;

    // With the skid entry, ready comes straight from a flop so out_ready never
    // reaches in_ready; without it, a pop frees the single entry in the same cycle.
    assign w_ready_base = SKID_EN ? r_ready : (~r_out_valid | out_ready);
    assign in_ready     = w_ready_base & ~flush;

    assign w_push = in_valid & in_ready;
    assign w_pop  = r_out_valid & out_ready;

    assign out_valid = r_out_valid;
    assign out_data  = r_main;
    assign occupancy = r_occ;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

    // NOTE: every state element uses <= so all reads below see pre-edge values.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state     <= EMPTY;
            r_main      <= '0;
            r_skid      <= '0;
            r_out_valid <= 1'b0;
            r_occ       <= 2'd0;
            r_ready     <= 1'b1;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (r_out_valid && !out_ready && !flush && r_stall_cnt != CNT_MAX) begin
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            end
            if (flush && r_out_valid && r_flush_cnt != CNT_MAX) begin
                r_flush_cnt <= r_flush_cnt + CNT_ONE;
            end

            if (flush) begin
                r_state     <= EMPTY;
                r_main      <= '0;
                r_skid      <= '0;
                r_out_valid <= 1'b0;
                r_occ       <= 2'd0;
                r_ready     <= 1'b1;
            end else begin
                case (r_state)
                    EMPTY: begin
                        if (w_push) begin
                            r_state     <= FULL;
                            r_main      <= in_data;
                            r_out_valid <= 1'b1;
                            r_occ       <= 2'd1;
                        end
                    end
                    FULL: begin
                        if (w_push && w_pop) begin
                            r_main <= in_data;
                        end else if (w_pop) begin
                            r_state     <= EMPTY;
                            r_main      <= '0;
                            r_out_valid <= 1'b0;
                            r_occ       <= 2'd0;
                        end else if (w_push && SKID_EN) begin
                            r_state <= SKID;
                            r_skid  <= in_data;
                            r_occ   <= 2'd2;
                            r_ready <= 1'b0;
                        end
                    end
                    SKID: begin
                        if (w_pop) begin
                            r_state <= FULL;
                            r_main  <= r_skid;
                            r_skid  <= '0;
                            r_occ   <= 2'd1;
                            r_ready <= 1'b1;
                        end
                    end
                    default: begin
                        r_state     <= EMPTY;
                        r_main      <= '0;
                        r_skid      <= '0;
                        r_out_valid <= 1'b0;
                        r_occ       <= 2'd0;
                        r_ready     <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Drives three pipe_stage_reg variants (skid, skid with 2-bit counters, no skid)
// from one stimulus and compares each against a queue-level reference model.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        arst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        out_ready = 1'b0;
    logic        flush = 1'b0;

    int total = 0;
    int bad = 0;
    bit run = 1'b0;

    always #5 clk = ~clk;

    logic        a_rdy, s_rdy, n_rdy;
    logic        a_ov, s_ov, n_ov;
    logic [31:0] a_od, s_od, n_od;
    logic [1:0]  a_occ, s_occ, n_occ;
    logic [15:0] a_sc, a_fc, n_sc, n_fc;
    logic [1:0]  s_sc, s_fc;

    pipe_stage_reg #(.WIDTH(32), .SKID_EN(1'b1), .CNT_WIDTH(16)) dut_a (
        .clk(clk), .arst_n(arst_n), .in_valid(in_valid), .in_ready(a_rdy),
        .in_data(in_data), .out_valid(a_ov), .out_ready(out_ready), .out_data(a_od),
        .flush(flush), .occupancy(a_occ), .stall_cnt(a_sc), .flush_cnt(a_fc)
    );

    pipe_stage_reg #(.WIDTH(32), .SKID_EN(1'b1), .CNT_WIDTH(2)) dut_s (
        .clk(clk), .arst_n(arst_n), .in_valid(in_valid), .in_ready(s_rdy),
        .in_data(in_data), .out_valid(s_ov), .out_ready(out_ready), .out_data(s_od),
        .flush(flush), .occupancy(s_occ), .stall_cnt(s_sc), .flush_cnt(s_fc)
    );

    pipe_stage_reg #(.WIDTH(32), .SKID_EN(1'b0), .CNT_WIDTH(16)) dut_n (
        .clk(clk), .arst_n(arst_n), .in_valid(in_valid), .in_ready(n_rdy),
        .in_data(in_data), .out_valid(n_ov), .out_ready(out_ready), .out_data(n_od),
        .flush(flush), .occupancy(n_occ), .stall_cnt(n_sc), .flush_cnt(n_fc)
    );

    logic        w_rdy[3];
    logic        w_ov[3];
    logic [31:0] w_od[3];
    logic [1:0]  w_occ[3];
    logic [31:0] w_sc[3];
    logic [31:0] w_fc[3];

    assign w_rdy[0] = a_rdy;  assign w_rdy[1] = s_rdy;  assign w_rdy[2] = n_rdy;
    assign w_ov[0]  = a_ov;   assign w_ov[1]  = s_ov;   assign w_ov[2]  = n_ov;
    assign w_od[0]  = a_od;   assign w_od[1]  = s_od;   assign w_od[2]  = n_od;
    assign w_occ[0] = a_occ;  assign w_occ[1] = s_occ;  assign w_occ[2] = n_occ;
    assign w_sc[0]  = {16'd0, a_sc};
    assign w_sc[1]  = {30'd0, s_sc};
    assign w_sc[2]  = {16'd0, n_sc};
    assign w_fc[0]  = {16'd0, a_fc};
    assign w_fc[1]  = {30'd0, s_fc};
    assign w_fc[2]  = {16'd0, n_fc};

    // Reference model: each variant is a FIFO of capacity 2 (skid) or 1 (no skid).
    string       nm[3]      = '{"a", "s", "n"};
    bit          skid_en[3] = '{1'b1, 1'b1, 1'b0};
    int          sat[3]     = '{65535, 3, 65535};
    logic [31:0] m_q[3][$];
    int          m_stall[3] = '{0, 0, 0};
    int          m_flush[3] = '{0, 0, 0};

    function automatic bit exp_ready(int k);
        if (flush) return 1'b0;
        if (skid_en[k]) return m_q[k].size() < 2;
        return (m_q[k].size() == 0) || out_ready;
    endfunction

    function automatic logic [31:0] exp_head(int k);
        if (m_q[k].size() == 0) return 32'd0;
        return m_q[k][0];
    endfunction

    always @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int k = 0; k < 3; k++) begin
                m_q[k].delete();
                m_stall[k] = 0;
                m_flush[k] = 0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                bit push;
                bit pop;
                push = in_valid && exp_ready(k);
                pop  = (m_q[k].size() > 0) && out_ready;
                if (m_q[k].size() > 0 && !out_ready && !flush && m_stall[k] < sat[k])
                    m_stall[k]++;
                if (flush && m_q[k].size() > 0 && m_flush[k] < sat[k])
                    m_flush[k]++;
                if (flush) begin
                    m_q[k].delete();
                end else begin
                    if (pop) void'(m_q[k].pop_front());
                    if (push) m_q[k].push_back(in_data);
                end
            end
        end
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (run) begin
            for (int k = 0; k < 3; k++) begin
                check($sformatf("%s.out_valid", nm[k]), 32'(w_ov[k]), 32'(m_q[k].size() > 0));
                check($sformatf("%s.out_data", nm[k]), w_od[k], exp_head(k));
                check($sformatf("%s.occupancy", nm[k]), 32'(w_occ[k]), 32'(m_q[k].size()));
                check($sformatf("%s.in_ready", nm[k]), 32'(w_rdy[k]), 32'(exp_ready(k)));
                check($sformatf("%s.stall_cnt", nm[k]), w_sc[k], 32'(m_stall[k]));
                check($sformatf("%s.flush_cnt", nm[k]), w_fc[k], 32'(m_flush[k]));
            end
            check("n.occ_max1", 32'(n_occ <= 2'd1), 32'd1);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
        arst_n    = 1'b0;
        #3;
        arst_n    = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] pv;
        logic [10:0] pr;
        logic [31:0] sat_exp[6];

        #1 arst_n = 1'b0;
        #2;
        run = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst.%s.out_valid", nm[k]), 32'(w_ov[k]), 32'd0);
            check($sformatf("rst.%s.out_data", nm[k]), w_od[k], 32'd0);
            check($sformatf("rst.%s.occupancy", nm[k]), 32'(w_occ[k]), 32'd0);
            check($sformatf("rst.%s.in_ready", nm[k]), 32'(w_rdy[k]), 32'd1);
            check($sformatf("rst.%s.stall_cnt", nm[k]), w_sc[k], 32'd0);
        end
        @(negedge clk);
        #2 arst_n = 1'b1;

        // Streaming
        out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h1;
        step(); check("stream.d1", a_od, 32'h1); check("stream.occ1", 32'(a_occ), 32'd1);
        in_data = 32'h2;
        step(); check("stream.d2", a_od, 32'h2);
        in_data = 32'h3;
        step(); check("stream.d3", a_od, 32'h3); check("stream.occ3", 32'(a_occ), 32'd1);
        in_valid = 1'b0;
        step(); check("stream.bubble", a_od, 32'h0); check("stream.stall", 32'(a_sc), 32'd0);

        // Backpressure into the skid entry
        step(); do_reset();
        in_valid = 1'b1; in_data = 32'hA;
        step(); check("bp.dA", a_od, 32'hA); check("bp.stall0", 32'(a_sc), 32'd0);
        in_data = 32'hB;
        step(); check("bp.occ2", 32'(a_occ), 32'd2); check("bp.rdy0", 32'(a_rdy), 32'd0);
        check("bp.stall1", 32'(a_sc), 32'd1);
        in_valid = 1'b0;
        step(); check("bp.stall2", 32'(a_sc), 32'd2);
        out_ready = 1'b1; #1;
        check("bp.rdy_still0", 32'(a_rdy), 32'd0);
        step(); check("bp.dB", a_od, 32'hB); check("bp.rdy1", 32'(a_rdy), 32'd1);
        check("bp.occ1", 32'(a_occ), 32'd1);
        step(); check("bp.empty", 32'(a_ov), 32'd0); check("bp.stall_hold", 32'(a_sc), 32'd2);

        // Flush from SKID with a beat offered
        do_reset();
        in_valid = 1'b1; in_data = 32'h11;
        step(); in_data = 32'h22;
        step(); check("fl.occ2", 32'(a_occ), 32'd2);
        flush = 1'b1; in_data = 32'h33; #1;
        check("fl.rdy0", 32'(a_rdy), 32'd0);
        step(); check("fl.ov0", 32'(a_ov), 32'd0); check("fl.od0", a_od, 32'd0);
        check("fl.occ0", 32'(a_occ), 32'd0); check("fl.cnt1", 32'(a_fc), 32'd1);
        flush = 1'b0; in_valid = 1'b0;
        step(); check("fl.dropped", 32'(a_ov), 32'd0); check("fl.rdy1", 32'(a_rdy), 32'd1);
        flush = 1'b1;
        step(); check("fl.empty_nocount", 32'(a_fc), 32'd1);
        flush = 1'b0; in_valid = 1'b1; in_data = 32'h44; out_ready = 1'b1;
        step(); in_valid = 1'b0; flush = 1'b1;
        step(); check("fl.with_pop", 32'(a_fc), 32'd2); check("fl.pop_ov0", 32'(a_ov), 32'd0);
        flush = 1'b0;

        // Reset in the middle of a backpressured transfer
        step(); do_reset();
        in_valid = 1'b1; in_data = 32'h66;
        step(); in_data = 32'h77;
        step(); in_valid = 1'b0;
        repeat (4) step();
        check("mr.stall5", 32'(a_sc), 32'd5); check("mr.occ2", 32'(a_occ), 32'd2);
        #2 arst_n = 1'b0;
        #1;
        check("mr.ov", 32'(a_ov), 32'd0); check("mr.od", a_od, 32'd0);
        check("mr.occ", 32'(a_occ), 32'd0); check("mr.rdy", 32'(a_rdy), 32'd1);
        check("mr.stall", 32'(a_sc), 32'd0); check("mr.fcnt", 32'(a_fc), 32'd0);
        in_valid = 1'b1; in_data = 32'h88;
        #2 arst_n = 1'b1;
        step(); check("mr.first_push", a_od, 32'h88); check("mr.fcnt_after", 32'(a_fc), 32'd0);

        // Counter saturation with 2-bit counters
        do_reset();
        in_valid = 1'b1; in_data = 32'h7;
        step(); check("sat.start", 32'(s_sc), 32'd0);
        in_valid = 1'b0;
        sat_exp = '{32'd1, 32'd2, 32'd3, 32'd3, 32'd3, 32'd3};
        for (int i = 0; i < 6; i++) begin
            step();
            check($sformatf("sat.stall%0d", i), 32'(s_sc), sat_exp[i]);
        end

        // No-skid variant: combinational ready while full and draining
        out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h55; #1;
        check("ns.rdy", 32'(n_rdy), 32'd1);
        step(); check("ns.d55", n_od, 32'h55); check("ns.occ", 32'(n_occ), 32'd1);
        in_valid = 1'b0;
        step(); check("ns.drained", 32'(n_ov), 32'd0);

        // Mixed valid/ready patterns with two flushes, ordering checked by the model
        pv = 16'b1011_0111_0010_1101;
        pr = 11'b110_0101_1011;
        for (int i = 0; i < 48; i++) begin
            in_valid  = pv[i % 16];
            out_ready = pr[i % 11];
            in_data   = 32'h1000 + 32'(i);
            flush     = (i == 30) || (i == 37);
            step();
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (3) step();
        check("end.empty", 32'(a_ov), 32'd0);

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, the payload width in bits (1 to 1024).
REQ-002 The block SHALL have parameter SKID_EN, default 1: 1 adds a skid entry and registers in_ready; 0 gives a single entry with a combinational ready path.
REQ-003 The block SHALL have parameter CNT_WIDTH, default 16, the width of the performance counters (2 to 32).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-005 The block SHALL have port arst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port in_valid, input, 1 bit: the upstream stage presents a beat.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block can accept a beat this cycle.
REQ-008 The block SHALL have port in_data, input, WIDTH bits: the upstream payload.
REQ-009 The block SHALL have port out_valid, output, 1 bit: the main entry holds a beat.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the downstream stage consumes the beat.
REQ-011 The block SHALL have port out_data, output, WIDTH bits: the main entry payload.
REQ-012 The block SHALL have port flush, input, 1 bit: synchronous kill of all held beats.
REQ-013 The block SHALL have port occupancy, output, 2 bits: the number of valid entries (0 to 2).
REQ-014 The block SHALL have port stall_cnt, output, CNT_WIDTH bits: the backpressure cycle counter.
REQ-015 The block SHALL have port flush_cnt, output, CNT_WIDTH bits: the count of flushes that killed at least one beat.

Function
REQ-016 A push SHALL occur when in_valid & in_ready; a pop SHALL occur when out_valid & out_ready.
REQ-017 The state machine SHALL have the states EMPTY, FULL and SKID; SKID SHALL be unreachable when SKID_EN=0.
REQ-018 In EMPTY, a push SHALL move the block to FULL with main <= in_data; otherwise the block SHALL stay in EMPTY.
REQ-019 In FULL, push & pop SHALL keep the block in FULL with main <= in_data.
REQ-020 In FULL, a pop alone SHALL move the block to EMPTY; the block SHALL stay in FULL when neither occurs.
REQ-021 In FULL, a push alone SHALL move the block to SKID with skid <= in_data when SKID_EN=1; this case SHALL be impossible when SKID_EN=0.
REQ-022 In SKID, a pop SHALL move the block to FULL with main <= skid and skid <= 0; otherwise the block SHALL stay in SKID.
REQ-023 When SKID_EN=1, in_ready SHALL be (state != SKID) and registered, with no combinational path from out_ready.
REQ-024 When SKID_EN=0, in_ready SHALL be ~out_valid | out_ready.
REQ-025 While flush=1, in_ready SHALL be forced to 0.
REQ-026 out_valid SHALL be (state != EMPTY), and out_data SHALL equal main.
REQ-027 main SHALL be all-zero whenever out_valid=0, and skid SHALL be zero outside SKID, so bubbles carry zeros.
REQ-028 Latency SHALL be 1 cycle: a beat pushed at edge N is visible on out_* after edge N.
REQ-029 Beats SHALL leave in push order, with none lost or duplicated except on flush.
REQ-030 On flush=1 at an edge, the next state SHALL be EMPTY with main and skid zeroed, whatever the current state, in_valid or out_ready.
REQ-031 flush SHALL take priority over a simultaneous pop or push.
REQ-032 A pop coinciding with flush SHALL still complete downstream, because out_valid was high in that cycle.
REQ-033 occupancy SHALL read 0 in EMPTY, 1 in FULL and 2 in SKID.
REQ-034 stall_cnt SHALL increment by 1 each cycle with out_valid & ~out_ready & ~flush, saturating at all-ones.
REQ-035 flush_cnt SHALL increment by 1 each cycle with flush & out_valid, saturating at all-ones.
REQ-036 The counters SHALL never wrap to 0 except on reset.

Reset
REQ-037 When arst_n=0, the block SHALL asynchronously set state=EMPTY, main=0, skid=0, stall_cnt=0 and flush_cnt=0.
REQ-038 During reset the outputs SHALL be out_valid=0, out_data=0, occupancy=0, in_ready=1 when SKID_EN=1 and in_ready=1 when SKID_EN=0.
REQ-039 Reset asserted mid-transfer SHALL discard held beats without counting them in flush_cnt.
REQ-040 Deassertion SHALL be synchronised externally, and the first push SHALL be accepted at the first edge after deassertion.

Verification
REQ-041 The bench SHALL cover streaming: SKID_EN=1, out_ready=1, push 0x1,0x2,0x3 on consecutive cycles -> out_data 0x1,0x2,0x3 one cycle later each, occupancy=1, stall_cnt=0.
REQ-042 The bench SHALL cover backpressure: push 0xA then 0xB with out_ready=0 -> occupancy=2, in_ready=0, stall_cnt increments by 1 per cycle; raising out_ready pops 0xA then 0xB, and in_ready returns 1 one cycle after the first pop.
REQ-043 The bench SHALL cover flush: in SKID with out_ready=0, assert flush for 1 cycle with in_valid=1 -> next cycle out_valid=0, out_data=0, occupancy=0, flush_cnt=1, and the in_data beat is dropped.
REQ-044 The bench SHALL cover saturation: CNT_WIDTH=2, hold out_valid=1, out_ready=0 for 6 cycles -> stall_cnt reads 1,2,3,3,3,3.
REQ-045 The bench SHALL cover SKID_EN=0: out_valid=1, out_ready=1, in_valid=1 with data 0x55 -> in_ready=1 in the same cycle, out_data=0x55 next cycle, occupancy never exceeds 1.
REQ-046 The bench SHALL cover reset mid-operation: occupancy=2, stall_cnt=5, assert arst_n=0 between edges -> all outputs reach their reset values immediately, without waiting for clk.
